// File: rtl/add_sub_initiator.sv
// Command-side initiator for an ADD_SUB datapath: issues operands, tracks the expected
// result through a pipeline matching ADD_SUB latency, and queues tagged responses in order.
module add_sub_initiator #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_add,
  output logic [7:0] a0,
  output logic [7:0] b0,
  output logic       doAdd0,
  input  logic [8:0] result0,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_result,
  output logic       rsp_mismatch,
  output logic [7:0] err_count
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  // Stage 0 sits alongside a0/b0; the tail lines up with result0 after LATENCY more edges.
  localparam int STAGES = LATENCY + 1;

  logic              accept;
  logic              pop;
  logic              push;
  logic              push_mis;
  logic [8:0]        exp_next;
  logic [8:0]        exp_pipe [STAGES];
  logic [STAGES-1:0] vld_pipe;
  logic [9:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     outstanding;

  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = vld_pipe[STAGES-1];
  assign push_mis  = result0 != exp_pipe[STAGES-1];
  assign exp_next  = cmd_add ? ({1'b0, cmd_a} + {1'b0, cmd_b})
                             : ({1'b0, cmd_a} - {1'b0, cmd_b});

  // Credits count every accepted command until it is popped, so this is registered-only.
  assign cmd_ready    = outstanding < CW'(DEPTH);
  assign rsp_valid    = fifo_cnt != '0;
  assign rsp_result   = rsp_valid ? mem[rd_ptr][9:1] : 9'd0;
  assign rsp_mismatch = rsp_valid ? mem[rd_ptr][0]   : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0     <= '0;
      b0     <= '0;
      doAdd0 <= 1'b0;
    end else if (accept) begin
      a0     <= cmd_a;
      b0     <= cmd_b;
      doAdd0 <= cmd_add;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < STAGES; i++) exp_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-2:0], accept};
      exp_pipe[0] <= exp_next;
      for (int i = 1; i < STAGES; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {result0, push_mis};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      err_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(accept) - CW'(pop);
      if (push && push_mis && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_add_sub_initiator.sv
// Randomized bench for add_sub_initiator with a queue-based reference model and a
// small faulty-able ADD_SUB stand-in.
module tb_add_sub_initiator;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_add = 1'b0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       doAdd0;
  logic [8:0] result0 = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [8:0] rsp_result;
  logic       rsp_mismatch;
  logic [7:0] err_count;

  logic corrupt = 1'b0;
  logic bad_q = 1'b0;

  int total = 0;
  int bad = 0;

  add_sub_initiator #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_add(cmd_add),
    .a0(a0), .b0(b0), .doAdd0(doAdd0), .result0(result0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_mismatch(rsp_mismatch),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // One-stage ADD_SUB; a command flagged corrupt produces a zero result.
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) bad_q <= corrupt;
    result0 <= bad_q ? 9'd0 : (doAdd0 ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a0} - {1'b0, b0}));
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int res;
    bit mis;
    int vis;
  } entry_t;

  entry_t q[$];
  int     ncyc = 0;
  int     pushed_bad = 0;

  always @(negedge clk) begin
    bit     exp_valid;
    bit     exp_rdy;
    int     e;
    int     act;
    entry_t en;
    ncyc++;
    if (!rst_n) begin
      q.delete();
      pushed_bad = 0;
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_a0", int'(a0), 0);
      chk("rst_b0", int'(b0), 0);
      chk("rst_doAdd0", int'(doAdd0), 0);
      chk("rst_rsp_result", int'(rsp_result), 0);
      chk("rst_rsp_mismatch", int'(rsp_mismatch), 0);
    end else begin
      foreach (q[i]) if (q[i].vis == ncyc && q[i].mis) pushed_bad++;
      exp_valid = (q.size() > 0) && (q[0].vis <= ncyc);
      exp_rdy   = q.size() < DEPTH;
      chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
      chk("cmd_ready", int'(cmd_ready), int'(exp_rdy));
      chk("err_count", int'(err_count), (pushed_bad > 255) ? 255 : pushed_bad);
      if (exp_valid) begin
        chk("rsp_result", int'(rsp_result), q[0].res);
        chk("rsp_mismatch", int'(rsp_mismatch), int'(q[0].mis));
      end
      if (exp_valid && rsp_ready) void'(q.pop_front());
      if (cmd_valid && exp_rdy) begin
        if (cmd_add) e = int'(cmd_a) + int'(cmd_b);
        else         e = (int'(cmd_a) - int'(cmd_b) + 512) % 512;
        act    = corrupt ? 0 : e;
        en.res = act;
        en.mis = (act != e);
        en.vis = ncyc + LATENCY + 2;
        q.push_back(en);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic add, input logic bd);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_add   = add;
    corrupt   = bd;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=cmd_ready_low expected=accept within 50 cycles");
    end
    step();
    cmd_valid = 1'b0;
    corrupt   = 1'b0;
  endtask

  initial begin
    int acc;
    bit r;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_add   = 1'($urandom);
      rsp_ready = 1'($urandom);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    step();
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);

    // Add and latency
    send(8'd200, 8'd100, 1'b1, 1'b0);
    chk("add_a0", int'(a0), 200);
    chk("add_doAdd0", int'(doAdd0), 1);
    step();
    chk("add_not_yet_valid", int'(rsp_valid), 0);
    step();
    chk("add_valid", int'(rsp_valid), 1);
    chk("add_result", int'(rsp_result), 300);
    chk("add_mismatch", int'(rsp_mismatch), 0);
    repeat (4) step();

    // Subtract wrap, in order
    rsp_ready = 1'b0;
    send(8'd3, 8'd5, 1'b0, 1'b0);
    send(8'd0, 8'd255, 1'b0, 1'b0);
    repeat (3) step();
    chk("sub_first", int'(rsp_result), 'h1FE);
    chk("sub_first_mis", int'(rsp_mismatch), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("sub_second", int'(rsp_result), 'h101);
    chk("sub_second_mis", int'(rsp_mismatch), 0);
    rsp_ready = 1'b1;
    repeat (4) step();

    // Backpressure: 6 offered, 4 accepted
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 6) begin
        cmd_valid = 1'b1;
        cmd_a     = 8'(acc * 10);
        cmd_b     = 8'(acc);
        cmd_add   = 1'b1;
      end else cmd_valid = 1'b0;
      r = cmd_ready;
      step();
      if (r) acc++;
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_cmd_ready_low", int'(cmd_ready), 0);
    rsp_ready = 1'b1;
    for (int i = acc; i < 6; i++) send(8'(i * 10), 8'(i), 1'b1, 1'b0);
    repeat (8) step();

    // Fault injection and saturation
    send(8'd1, 8'd1, 1'b1, 1'b1);
    step();
    step();
    chk("fault_result", int'(rsp_result), 0);
    chk("fault_mismatch", int'(rsp_mismatch), 1);
    chk("fault_err_count", int'(err_count), 1);
    for (int i = 0; i < 300; i++) send(8'd1, 8'd1, 1'b1, 1'b1);
    repeat (8) step();
    chk("err_saturated", int'(err_count), 255);

    // Reset mid-operation: 2 in FIFO, 1 in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i + 1), 8'd2, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_err_count", int'(err_count), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    chk("mid_rst_a0", int'(a0), 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) step();
    chk("no_stale_rsp", int'(rsp_valid), 0);
    send(8'd7, 8'd8, 1'b1, 1'b0);
    step();
    step();
    chk("post_rst_valid", int'(rsp_valid), 1);
    chk("post_rst_result", int'(rsp_result), 15);
    repeat (4) step();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cmd_valid = ($urandom_range(9) < 7);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      cmd_add   = 1'($urandom);
      corrupt   = ($urandom_range(7) == 0);
      rsp_ready = ($urandom_range(9) < 6);
      step();
    end
    cmd_valid = 1'b0;
    corrupt   = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) step();
    chk("drained", int'(rsp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
